// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding and default geometry.
package instr_fetch_pkg;

   localparam int OP_W_DEF      = 26;
   localparam int PTR_W_DEF     = 4;
   localparam int MEM_DEPTH_DEF = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT,
      PRESENT,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Pointer register with clear, load and increment controls. One instance
// serves as the load address in LOAD and as the program counter when fetching.
module fetch_pc #(
   parameter int PTR_W = instr_fetch_pkg::PTR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic             load,
   input  logic [PTR_W-1:0] load_value,
   output logic [PTR_W-1:0] ptr
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset || clear)
         ptr <= '0;
      else if (load)
         ptr <= load_value;
      else if (inc)
         ptr <= ptr + PTR_W'(1);
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: loads program words into an external memory,
// then fetches them in order for the execution engine.
// Optional macro INSTR_FETCH_JUMP_EN enables jump_valid/jump_addr redirection.
module instr_fetch_ctrl
   import instr_fetch_pkg::*;
#(
   parameter int OP_W      = OP_W_DEF,
   parameter int PTR_W     = PTR_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_en,
   input  logic             load_valid,
   input  logic [OP_W-1:0]  load_data,
   output logic             load_ready,
   input  logic             start,
   input  logic [PTR_W-1:0] prog_len,
   output logic [PTR_W-1:0] prog_pointer,
   output logic             write_data,
   output logic [OP_W-1:0]  data_to_write,
   input  logic [OP_W-1:0]  opcode,
   output logic [OP_W-1:0]  instr_out,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic             busy,
   output logic             done,
   input  logic             jump_valid,
   input  logic [PTR_W-1:0] jump_addr
);

   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(MEM_DEPTH);
   localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(MEM_DEPTH - 1);

   fetch_state_t     state;
   logic [PTR_W-1:0] len;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] start_len;
   logic             idle_like;
   logic             go_load;
   logic             go_start;
   logic             accept;
   logic             last;
   logic             jump_take;
   logic             jump_ok;
   logic             pc_clear;
   logic             pc_inc;
   logic             pc_load;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign go_load   = idle_like && load_en;
   assign go_start  = idle_like && !load_en && start;
   assign start_len = (prog_len > DEPTH_P) ? DEPTH_P : prog_len;
   assign accept    = (state == PRESENT) && instr_valid && instr_ready;
   assign last      = ({1'b0, ptr} + (PTR_W+1)'(1)) == {1'b0, len};

   // Write strobe is combinational but forced low while reset is asserted so
   // a reset landing mid-load can never commit another word.
   assign load_ready    = (state == LOAD) && (ptr < DEPTH_P) && !reset;
   assign write_data    = load_valid && load_ready;
   assign data_to_write = write_data ? load_data : '0;
   assign prog_pointer  = ptr;
   assign busy          = (state == LOAD) || (state == ISSUE) ||
                          (state == WAIT) || (state == PRESENT);
   assign done          = (state == DONE);

`ifdef INSTR_FETCH_JUMP_EN
   assign jump_take = accept && jump_valid;
   assign jump_ok   = jump_addr < len;
`else
   logic unused_jump;
   assign unused_jump = ^{jump_valid, jump_addr};
   assign jump_take   = 1'b0;
   assign jump_ok     = 1'b0;
`endif

   assign pc_clear = go_load || go_start;
   assign pc_load  = jump_take && jump_ok;
   assign pc_inc   = write_data || (accept && !jump_take && !last);

   fetch_pc #(.PTR_W(PTR_W)) u_pc (
      .clk        (clk),
      .reset      (reset),
      .clear      (pc_clear),
      .inc        (pc_inc),
      .load       (pc_load),
      .load_value (jump_addr),
      .ptr        (ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         len         <= '0;
         instr_out   <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_en) begin
                  state <= LOAD;
               end else if (start) begin
                  len   <= start_len;
                  state <= (start_len == '0) ? DONE : ISSUE;
               end
            end
            LOAD: begin
               if (!load_en || !load_ready || (write_data && ptr == LAST_P))
                  state <= IDLE;
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // Memory returns mem[ptr] one clock after ISSUE presented it.
               instr_out   <= opcode;
               instr_valid <= 1'b1;
               state       <= PRESENT;
            end
            PRESENT: begin
               if (accept) begin
                  instr_valid <= 1'b0;
                  if (jump_take)
                     state <= jump_ok ? ISSUE : DONE;
                  else
                     state <= last ? DONE : ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl with a behavioural registered-read
// memory; directed load, fetch, stall, length-boundary and reset scenarios.
module tb_instr_fetch_ctrl;

   localparam int OP_W      = 26;
   localparam int PTR_W     = 4;
   localparam int MEM_DEPTH = 10;

   typedef struct {
      logic [PTR_W-1:0] a;
      logic [OP_W-1:0]  d;
   } wr_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             load_en = 1'b0;
   logic             load_valid = 1'b0;
   logic             start = 1'b0;
   logic             instr_ready = 1'b0;
   logic             jump_valid = 1'b0;
   logic [PTR_W-1:0] prog_len = '0;
   logic [PTR_W-1:0] jump_addr = '0;
   logic [PTR_W-1:0] prog_pointer;
   logic [OP_W-1:0]  load_data;
   logic [OP_W-1:0]  data_to_write;
   logic [OP_W-1:0]  opcode = '0;
   logic [OP_W-1:0]  instr_out;
   logic             load_ready;
   logic             write_data;
   logic             instr_valid;
   logic             busy;
   logic             done;

   logic [OP_W-1:0]  mem [16];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int issue_ref = 0;
   int n_acc = 0;
   int n_wr = 0;
   int a0;
   int n0;
   logic valid_q = 1'b0;
   wr_t wr_e;
   logic [OP_W-1:0] ex_i;

   logic [OP_W-1:0] exp_instr [$];
   wr_t             exp_wr [$];

   always #5 clk = ~clk;

   instr_fetch_ctrl #(.OP_W(OP_W), .PTR_W(PTR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .load_en       (load_en),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .start         (start),
      .prog_len      (prog_len),
      .prog_pointer  (prog_pointer),
      .write_data    (write_data),
      .data_to_write (data_to_write),
      .opcode        (opcode),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .busy          (busy),
      .done          (done),
      .jump_valid    (jump_valid),
      .jump_addr     (jump_addr)
   );

   // Program word k is k+1; the loader presents the word for the current address.
   function automatic logic [OP_W-1:0] word_at(input logic [PTR_W-1:0] a);
      return (int'(a) < MEM_DEPTH) ? OP_W'(int'(a) + 1) : '0;
   endfunction

   assign load_data = word_at(prog_pointer);

   always @(posedge clk) begin
      if (write_data) mem[prog_pointer] <= data_to_write;
      opcode <= mem[prog_pointer];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for(input string nm, input int which, input int budget);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((which == 0 && done) || (which == 1 && instr_valid) || (which == 2 && !busy)) begin
            hit = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles", nm, budget);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ptr"},   32'(prog_pointer), 0);
      check({tag, "_wr"},    32'(write_data), 0);
      check({tag, "_dtw"},   32'(data_to_write), 0);
      check({tag, "_instr"}, 32'(instr_out), 0);
      check({tag, "_valid"}, 32'(instr_valid), 0);
      check({tag, "_lrdy"},  32'(load_ready), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_done"},  32'(done), 0);
   endtask

   // Monitor: scoreboards memory writes and presented instructions, and
   // measures the ISSUE-to-valid latency.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (write_data) begin
            if (exp_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wr_unexpected: addr %0h data %0h", prog_pointer, data_to_write);
            end else begin
               wr_e = exp_wr.pop_front();
               check("wr_addr", 32'(prog_pointer), 32'(wr_e.a));
               check("wr_data", 32'(data_to_write), 32'(wr_e.d));
            end
            n_wr++;
         end else begin
            check("dtw_zero", 32'(data_to_write), 0);
         end
         if (instr_valid && !valid_q)
            check("latency", 32'(cyc - issue_ref), 3);
         if (instr_valid && instr_ready) begin
            if (exp_instr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL instr_unexpected: got %0h", instr_out);
            end else begin
               ex_i = exp_instr.pop_front();
               check("instr_out", 32'(instr_out), 32'(ex_i));
            end
            n_acc++;
            issue_ref = cyc;
         end
         if (start && !busy && !load_en)
            issue_ref = cyc;
      end
      valid_q = instr_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;

      repeat (2) step;
      @(negedge clk);
      check_reset_outputs("por");
      step;
      reset = 1'b0;

      // Full program load: ten back-to-back writes, then back to IDLE.
      for (int i = 0; i < MEM_DEPTH; i++) exp_wr.push_back('{a: PTR_W'(i), d: OP_W'(i + 1)});
      n0 = n_wr;
      load_en = 1'b1;
      load_valid = 1'b1;
      repeat (11) step;
      load_en = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      check("load_count", 32'(n_wr - n0), 10);
      check("load_end_lrdy", 32'(load_ready), 0);
      check("load_end_busy", 32'(busy), 0);
      check("load_end_done", 32'(done), 0);

      // Three-instruction fetch with the engine always ready.
      step;
      for (int i = 1; i <= 3; i++) exp_instr.push_back(OP_W'(i));
      a0 = n_acc;
      instr_ready = 1'b1;
      prog_len = 4'd3;
      start = 1'b1;
      step;
      start = 1'b0;
      wait_for("done3", 0, 40);
      check("fetch3_count", 32'(n_acc - a0), 3);
      check("fetch3_busy", 32'(busy), 0);

      // Engine stalls for five cycles on the first instruction.
      step;
      exp_instr.push_back(OP_W'(1));
      exp_instr.push_back(OP_W'(2));
      a0 = n_acc;
      instr_ready = 1'b0;
      prog_len = 4'd2;
      start = 1'b1;
      step;
      start = 1'b0;
      wait_for("stall_valid", 1, 20);
      for (int i = 0; i < 5; i++) begin
         check("stall_instr", 32'(instr_out), 1);
         check("stall_ptr", 32'(prog_pointer), 0);
         check("stall_valid", 32'(instr_valid), 1);
         if (i < 4) @(negedge clk);
      end
      step;
      instr_ready = 1'b1;
      wait_for("stall_done", 0, 30);
      check("stall_count", 32'(n_acc - a0), 2);

      // Zero-length program from a fresh IDLE goes straight to DONE.
      step;
      reset = 1'b1;
      step;
      reset = 1'b0;
      prog_len = 4'd0;
      start = 1'b1;
      a0 = n_acc;
      step;
      start = 1'b0;
      @(negedge clk);
      check("len0_done", 32'(done), 1);
      check("len0_busy", 32'(busy), 0);
      repeat (4) @(negedge clk);
      check("len0_novalid", 32'(instr_valid), 0);
      check("len0_count", 32'(n_acc - a0), 0);

      // Over-long program is clipped to the memory depth.
      step;
      for (int i = 1; i <= MEM_DEPTH; i++) exp_instr.push_back(OP_W'(i));
      a0 = n_acc;
      prog_len = 4'd12;
      start = 1'b1;
      step;
      start = 1'b0;
      wait_for("len12_done", 0, 60);
      check("len12_count", 32'(n_acc - a0), 10);

      // Reset while the load is about to write address 4.
      step;
      for (int i = 0; i < 4; i++) exp_wr.push_back('{a: PTR_W'(i), d: OP_W'(i + 1)});
      n0 = n_wr;
      load_en = 1'b1;
      load_valid = 1'b1;
      repeat (5) step;
      reset = 1'b1;
      @(negedge clk);
      check("rst_load_wr", 32'(write_data), 0);
      check("rst_load_dtw", 32'(data_to_write), 0);
      check("rst_load_ptr_pre", 32'(prog_pointer), 4);
      step;
      @(negedge clk);
      check_reset_outputs("mid_load");
      check("rst_load_count", 32'(n_wr - n0), 4);
      step;
      reset = 1'b0;
      load_en = 1'b0;
      load_valid = 1'b0;

`ifdef INSTR_FETCH_JUMP_EN
      // Jump from instruction 1 to word 7, then sequential to the end.
      step;
      exp_instr.push_back(OP_W'(1));
      exp_instr.push_back(OP_W'(8));
      exp_instr.push_back(OP_W'(9));
      exp_instr.push_back(OP_W'(10));
      a0 = n_acc;
      prog_len = 4'd10;
      jump_addr = 4'd7;
      jump_valid = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      wait_for("jmp_valid", 1, 20);
      step;
      jump_valid = 1'b0;
      wait_for("jmp_done", 0, 40);
      check("jmp_count", 32'(n_acc - a0), 4);

      // Jump target past the program length ends the fetch.
      step;
      exp_instr.push_back(OP_W'(1));
      a0 = n_acc;
      jump_addr = 4'd11;
      jump_valid = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      wait_for("jmp_out_done", 0, 20);
      jump_valid = 1'b0;
      check("jmp_out_count", 32'(n_acc - a0), 1);
`endif

      step;
      repeat (3) @(negedge clk);
      check("sb_instr_empty", 32'(exp_instr.size()), 0);
      check("sb_wr_empty", 32'(exp_wr.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
